// File: rtl/bkm_pkg.sv
// Shared state encoding and default parameter values for the BKM step controller.
package bkm_pkg;

   localparam int DEF_W        = 64;
   localparam int DEF_N_ITER   = 64;
   localparam int DEF_STEP_LAT = 1;
   localparam int DEF_CNT_W    = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } bkm_state_t;

endpackage

// File: rtl/bkm_iter_cnt.sv
// BKM iteration index: clears to zero, increments without wrapping, flags the last index.
module bkm_iter_cnt
   import bkm_pkg::*;
#(
   parameter int N_ITER = DEF_N_ITER,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             srst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] n,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

   logic [CNT_W-1:0] n_reg;

   // Increment is blocked at the last index so the count can never wrap.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         n_reg <= '0;
      end else if (srst) begin
         n_reg <= '0;
      end else if (en) begin
         if (clr) begin
            n_reg <= '0;
         end else if (inc && (n_reg != LAST)) begin
            n_reg <= n_reg + CNT_W'(1);
         end
      end
   end

   assign n  = n_reg;
   assign tc = (n_reg == LAST);

endmodule

// File: rtl/bkm_step_ctrl.sv
// BKM iteration controller: sequences N_ITER issue/wait rounds against an external data step.
module bkm_step_ctrl
   import bkm_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int N_ITER   = DEF_N_ITER,
   parameter int STEP_LAT = DEF_STEP_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             srst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   in_X,
   input  logic [2*W-1:0]   in_Y,
   output logic             step_valid,
   output logic [CNT_W-1:0] step_n,
   output logic [2*W-1:0]   step_X_n,
   output logic [2*W-1:0]   step_Y_n,
   input  logic             step_done,
   input  logic [2*W-1:0]   step_X_next,
   input  logic [2*W-1:0]   step_Y_next,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_X,
   output logic [2*W-1:0]   out_Y,
   output logic             busy,
   output logic             err
);

   localparam logic [3:0] GUARD_INIT = 4'(STEP_LAT);

   bkm_state_t     state_reg, state_next;
   logic [2*W-1:0] x_reg, y_reg;
   logic           err_reg;
   logic [3:0]     guard_reg;
   logic           load_in, load_step, cnt_clr, cnt_inc, cnt_tc, stray_done;

   bkm_iter_cnt #(
      .N_ITER (N_ITER),
      .CNT_W  (CNT_W)
   ) u_iter_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .srst   (srst),
      .en     (enable),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .n      (step_n),
      .tc     (cnt_tc)
   );

   always_comb begin
      state_next = state_reg;
      load_in    = 1'b0;
      load_step  = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      in_ready   = 1'b0;
      step_valid = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               load_in    = 1'b1;
               cnt_clr    = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            step_valid = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (step_done) begin
               load_step = 1'b1;
               if (cnt_tc) begin
                  state_next = ST_DONE;
               end else begin
                  cnt_inc    = 1'b1;
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A step aborted by reset may still complete up to STEP_LAT cycles later;
   // guard_reg hides that late strobe from the protocol-error check.
   assign stray_done = step_done && (state_reg != ST_WAIT) && (guard_reg == 4'd0);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         err_reg   <= 1'b0;
         guard_reg <= GUARD_INIT;
      end else if (srst) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         err_reg   <= 1'b0;
         guard_reg <= GUARD_INIT;
      end else if (enable) begin
         state_reg <= state_next;
         if (load_in) begin
            x_reg <= in_X;
            y_reg <= in_Y;
         end else if (load_step) begin
            x_reg <= step_X_next;
            y_reg <= step_Y_next;
         end
         if (stray_done) begin
            err_reg <= 1'b1;
         end
         if (guard_reg != 4'd0) begin
            guard_reg <= guard_reg - 4'd1;
         end
      end
   end

   assign step_X_n = x_reg;
   assign step_Y_n = y_reg;
   assign out_X    = x_reg;
   assign out_Y    = y_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_bkm_step_ctrl.sv
// Self-checking bench: two controller instances (N_ITER=4/LAT=1 and N_ITER=1/LAT=3) with stub data steps.
module tb_bkm_step_ctrl;

   localparam int W = 8;
   localparam int BW = 2 * W;
   localparam int N_A = 4;
   localparam int L_A = 1;
   localparam int N_B = 1;
   localparam int L_B = 3;

   logic clk = 1'b0;
   logic arst_n, srst;
   int   errors = 0;
   int   checks = 0;

   // instance A
   logic          en_a, in_valid_a, in_ready_a, step_valid_a, step_done_a;
   logic          out_valid_a, out_ready_a, busy_a, err_a, inj_a;
   logic [2:0]    step_n_a;
   logic [BW-1:0] in_x_a, in_y_a, step_x_n_a, step_y_n_a, out_x_a, out_y_a;
   logic [BW-1:0] sx_a = '0;
   logic [BW-1:0] sy_a = '0;
   logic [3:0]    cnt_a = 4'd0;

   // instance B
   logic          in_valid_b, in_ready_b, step_valid_b, step_done_b;
   logic          out_valid_b, out_ready_b, busy_b, err_b;
   logic [0:0]    step_n_b;
   logic [BW-1:0] in_x_b, in_y_b, step_x_n_b, step_y_n_b, out_x_b, out_y_b;
   logic [BW-1:0] sx_b = '0;
   logic [BW-1:0] sy_b = '0;
   logic [3:0]    cnt_b = 4'd0;

   always #5 clk = ~clk;

   bkm_step_ctrl #(.W(W), .N_ITER(N_A), .STEP_LAT(L_A), .CNT_W(3)) dut_a (
      .clk(clk), .arst_n(arst_n), .srst(srst), .enable(en_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_X(in_x_a), .in_Y(in_y_a),
      .step_valid(step_valid_a), .step_n(step_n_a), .step_X_n(step_x_n_a), .step_Y_n(step_y_n_a),
      .step_done(step_done_a), .step_X_next(sx_a), .step_Y_next(sy_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_X(out_x_a), .out_Y(out_y_a),
      .busy(busy_a), .err(err_a)
   );

   bkm_step_ctrl #(.W(W), .N_ITER(N_B), .STEP_LAT(L_B), .CNT_W(1)) dut_b (
      .clk(clk), .arst_n(arst_n), .srst(srst), .enable(1'b1),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_X(in_x_b), .in_Y(in_y_b),
      .step_valid(step_valid_b), .step_n(step_n_b), .step_X_n(step_x_n_b), .step_Y_n(step_y_n_b),
      .step_done(step_done_b), .step_X_next(sx_b), .step_Y_next(sy_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_X(out_x_b), .out_Y(out_y_b),
      .busy(busy_b), .err(err_b)
   );

   // Stub data steps: return X+1, Y+1 exactly LAT cycles after step_valid, frozen by enable.
   always @(posedge clk) begin
      if (en_a) begin
         if (step_valid_a) begin
            cnt_a <= 4'(L_A);
            sx_a  <= step_x_n_a + 16'd1;
            sy_a  <= step_y_n_a + 16'd1;
         end else if (cnt_a != 4'd0) begin
            cnt_a <= cnt_a - 4'd1;
         end
      end
   end
   assign step_done_a = (cnt_a == 4'd1) | inj_a;

   always @(posedge clk) begin
      if (step_valid_b) begin
         cnt_b <= 4'(L_B);
         sx_b  <= step_x_n_b + 16'd1;
         sy_b  <= step_y_n_b + 16'd1;
      end else if (cnt_b != 4'd0) begin
         cnt_b <= cnt_b - 4'd1;
      end
   end
   assign step_done_b = (cnt_b == 4'd1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: every round adds one per component; latency is one accept cycle
   // plus N rounds of (issue + LAT), plus any cycles spent with enable low.
   function automatic int exp_lat(input int n, input int l, input int gaps);
      return 1 + n * (l + 1) + gaps;
   endfunction

   task automatic run_op_a(input logic [BW-1:0] x, input logic [BW-1:0] y,
                           input int rdy_delay, input int freeze_iter, input string tag);
      int t;
      int nexp;
      int gaps;
      logic [BW-1:0] ex, ey;
      gaps = (freeze_iter >= 0) ? 3 : 0;
      chk({tag, "_in_ready"}, in_ready_a, 1);
      in_valid_a = 1'b1;
      in_x_a = x;
      in_y_a = y;
      tick();
      in_valid_a = 1'b0;
      in_x_a = $urandom;
      in_y_a = $urandom;
      t = 1;
      nexp = 0;
      while (!out_valid_a && t < 400) begin
         if (step_valid_a) begin
            ex = x + BW'(nexp);
            chk({tag, "_step_n"}, step_n_a, nexp);
            chk({tag, "_step_x"}, step_x_n_a, ex);
            nexp++;
            if (freeze_iter == nexp - 1) begin
               tick();
               t++;
               en_a = 1'b0;
               repeat (3) begin
                  tick();
                  t++;
                  chk({tag, "_frz_n"}, step_n_a, nexp - 1);
                  chk({tag, "_frz_sv"}, step_valid_a, 0);
                  chk({tag, "_frz_busy"}, busy_a, 1);
               end
               en_a = 1'b1;
               continue;
            end
         end
         tick();
         t++;
      end
      ex = x + BW'(N_A);
      ey = y + BW'(N_A);
      $display("op %s: x=%0h y=%0h latency=%0d steps=%0d out=%0h/%0h", tag, x, y, t, nexp, out_x_a, out_y_a);
      chk({tag, "_latency"}, t, exp_lat(N_A, L_A, gaps));
      chk({tag, "_steps"}, nexp, N_A);
      chk({tag, "_out_x"}, out_x_a, ex);
      chk({tag, "_out_y"}, out_y_a, ey);
      for (int i = 0; i < rdy_delay; i++) begin
         tick();
         chk({tag, "_hold_valid"}, out_valid_a, 1);
         chk({tag, "_hold_x"}, out_x_a, ex);
         chk({tag, "_hold_y"}, out_y_a, ey);
         chk({tag, "_hold_rdy"}, in_ready_a, 0);
      end
      out_ready_a = 1'b1;
      tick();
      out_ready_a = 1'b0;
      chk({tag, "_ret_rdy"}, in_ready_a, 1);
      chk({tag, "_ret_valid"}, out_valid_a, 0);
   endtask

   initial begin
      int t;
      int nsv;
      logic [BW-1:0] rx, ry;
      arst_n = 1'b0;
      srst = 1'b0;
      en_a = 1'b1;
      inj_a = 1'b0;
      in_valid_a = 1'b0;
      out_ready_a = 1'b0;
      in_x_a = '0;
      in_y_a = '0;
      in_valid_b = 1'b0;
      out_ready_b = 1'b0;
      in_x_b = '0;
      in_y_b = '0;

      #3;
      chk("rst_in_ready", in_ready_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_step_valid", step_valid_a, 0);
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_step_n", step_n_a, 0);
      chk("rst_x", step_x_n_a, 0);
      chk("rst_b_in_ready", in_ready_b, 1);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (3) tick();

      // directed op with 5-cycle output backpressure
      run_op_a(16'd1, 16'd2, 5, -1, "basic");

      // spurious step_done while idle
      inj_a = 1'b1;
      tick();
      inj_a = 1'b0;
      $display("spurious done: err=%0b x=%0h y=%0h", err_a, step_x_n_a, step_y_n_a);
      chk("spur_err", err_a, 1);
      chk("spur_x", step_x_n_a, 16'd5);
      chk("spur_y", step_y_n_a, 16'd6);
      chk("spur_in_ready", in_ready_a, 1);

      for (int k = 0; k < 5; k++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         run_op_a(rx, ry, int'($urandom_range(0, 3)), -1, "rand");
      end
      chk("err_sticky", err_a, 1);

      // srst applies even with enable low
      en_a = 1'b0;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      en_a = 1'b1;
      $display("srst: err=%0b x=%0h in_ready=%0b", err_a, step_x_n_a, in_ready_a);
      chk("srst_err", err_a, 0);
      chk("srst_x", step_x_n_a, 0);
      chk("srst_in_ready", in_ready_a, 1);
      repeat (2) tick();

      // enable low for 3 cycles during WAIT of iteration 1
      run_op_a(16'd3, 16'd9, 0, 1, "freeze");

      // async reset in the middle of iteration 2
      in_valid_a = 1'b1;
      in_x_a = 16'd10;
      in_y_a = 16'd20;
      tick();
      in_valid_a = 1'b0;
      t = 0;
      while (!(step_valid_a && step_n_a == 3'd2) && t < 50) begin
         tick();
         t++;
      end
      chk("arst_reach_n2", (t < 50), 1);
      tick();
      #2;
      arst_n = 1'b0;
      #1;
      $display("arst: busy=%0b sv=%0b n=%0d x=%0h rdy=%0b", busy_a, step_valid_a, step_n_a, step_x_n_a, in_ready_a);
      chk("arst_busy", busy_a, 0);
      chk("arst_step_valid", step_valid_a, 0);
      chk("arst_step_n", step_n_a, 0);
      chk("arst_x", step_x_n_a, 0);
      chk("arst_in_ready", in_ready_a, 1);
      chk("arst_out_valid", out_valid_a, 0);
      #1;
      arst_n = 1'b1;
      tick();
      chk("arst_stale_err", err_a, 0);
      run_op_a(16'd1, 16'd2, 0, -1, "post_arst");
      chk("post_arst_err", err_a, 0);

      // single-iteration instance with longer step latency
      in_valid_b = 1'b1;
      in_x_b = 16'd3;
      in_y_b = 16'd7;
      tick();
      in_valid_b = 1'b0;
      t = 1;
      nsv = 0;
      while (!out_valid_b && t < 100) begin
         if (step_valid_b) begin
            nsv++;
            chk("b_step_n", step_n_b, 0);
         end
         tick();
         t++;
      end
      $display("op b: latency=%0d steps=%0d out=%0h/%0h", t, nsv, out_x_b, out_y_b);
      chk("b_latency", t, exp_lat(N_B, L_B, 0));
      chk("b_steps", nsv, 1);
      chk("b_out_x", out_x_b, 16'd4);
      chk("b_out_y", out_y_b, 16'd8);
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
      chk("b_ret_rdy", in_ready_b, 1);
      chk("b_err", err_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bkm_step_ctrl.md
BKM_STEP_CTRL -- requirements
Module: bkm_step_ctrl

Interface
REQ-001 SHALL have parameter W, default 64: binary operand width; all CSD buses are 2*W bits.
REQ-002 SHALL have parameter N_ITER, default 64: BKM iterations per operation, legal range 1..2^CNT_W.
REQ-003 SHALL have parameter STEP_LAT, default 1: fixed latency in cycles from step_valid to step_done, legal range 1..8.
REQ-004 SHALL have parameter CNT_W, default 6: iteration index width.
REQ-005 clk  in  1  rising-edge clock; the block has one clock; reset is asynchronous and active-low.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 srst  in  1  synchronous active-high reset.
REQ-008 enable  in  1  clock enable; when low, all state is held.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand handshake.
REQ-010 in_X, in_Y  in  2*W  initial X_0, Y_0 in CSD.
REQ-011 step_valid  out  1  one-cycle issue strobe to the data step.
REQ-012 step_n  out  CNT_W  current iteration index; also the LUT address.
REQ-013 step_X_n, step_Y_n  out  2*W  current X_n, Y_n to the data step.
REQ-014 step_done  in  1  data-step result-valid strobe.
REQ-015 step_X_next, step_Y_next  in  2*W  X_n+1, Y_n+1 from the data step.
REQ-016 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-017 out_X, out_Y  out  2*W  final X_N, Y_N.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, DONE; a state advances only on a cycle with enable=1.
REQ-021 IDLE: in_ready=1. On in_valid&in_ready: load in_X, in_Y into the X/Y registers, set n=0, go to ISSUE.
REQ-022 ISSUE: step_valid=1 for exactly one cycle, then go to WAIT.
REQ-023 WAIT, step_done=1:
- load step_X_next, step_Y_next into the X/Y registers;
- if n==N_ITER-1, go to DONE;
- otherwise increment n and go to ISSUE.
REQ-024 DONE: out_valid=1 and out_X/out_Y hold the X/Y registers; on out_ready, go to IDLE.
REQ-025 Within an operation, out_X/out_Y and step_X_n/step_Y_n SHALL equal the X/Y registers, and step_n SHALL equal n.
REQ-026 Latency: with the input handshake in cycle c0 and step_done returned STEP_LAT cycles after each step_valid, out_valid SHALL first assert in cycle c0+1+N_ITER*(STEP_LAT+1).
REQ-027 step_done outside WAIT SHALL be ignored for data and SHALL set err.
REQ-028 in_valid while busy SHALL be ignored; in_ready is low outside IDLE.
REQ-029 With enable=0, step_done SHALL be ignored; the data step is driven by the same enable, so it freezes in lockstep.
REQ-030 n never wraps; the final index is N_ITER-1.
REQ-031 out_valid and out_X/out_Y SHALL stay stable until out_ready is seen.

Reset
REQ-032 On arst_n low, asynchronously:
- state=IDLE, n=0, X/Y registers=0;
- step_valid=0, out_valid=0, busy=0, err=0, in_ready=1.
REQ-033 srst=1 SHALL apply the same values at the next clock edge, regardless of enable, aborting any operation in progress.
REQ-034 A step_done arriving after a mid-operation reset SHALL be ignored without setting err.

Structure
REQ-035 The state encoding and the default parameter constants SHALL reside in a shared package bkm_pkg.
REQ-036 The iteration counter SHALL be one sub-module, bkm_iter_cnt (load-zero, increment, terminal-count output); the FSM and registers SHALL be in the top module.

Verification
REQ-037 N_ITER=4, STEP_LAT=1, in_X=1, in_Y=2 accepted at c0, stub returns X+1, Y+1 -> step_n sequence 0,1,2,3; out_valid first at c0+9; out_X=5, out_Y=6.
REQ-038 Same setup, out_ready held low 5 cycles -> out_valid and out_X/out_Y stable for those cycles; next in_ready one cycle after out_ready.
REQ-039 Spurious step_done in IDLE -> err=1 and the X/Y registers unchanged; err cleared only by srst or arst_n.
REQ-040 enable=0 for 3 cycles during WAIT -> state and n frozen; completion delayed by exactly 3 cycles.
REQ-041 arst_n pulsed during iteration n=2 -> all outputs at reset values immediately; the next operation runs cleanly from n=0.
REQ-042 N_ITER=1, STEP_LAT=3 -> single step_valid with step_n=0; out_valid at c0+5.
